// File: rtl/icmp_responder_pkg.sv
// Shared ICMP constants, FSM state type and the one's-complement fold helper
// used by the ICMP echo responder.
package icmp_responder_pkg;

    localparam logic [7:0] ICMP_TYPE_ECHO_REQ = 8'd8;
    localparam logic [7:0] ICMP_TYPE_ECHO_REP = 8'd0;
    localparam logic [7:0] ICMP_TYPE_UNREACH  = 8'd3;
    localparam int         ICMP_HDR_LEN       = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        TXREQ   = 3'd4,
        TX      = 3'd5,
        DISCARD = 3'd6
    } icmp_state_t;

    // Two carry-add folds of a 32-bit sum; the second fold can never overflow.
    function automatic logic [15:0] csum_fold(input logic [31:0] s);
        logic [16:0] once;
        once = {1'b0, s[15:0]} + {1'b0, s[31:16]};
        return once[15:0] + {15'h0, once[16]};
    endfunction

endpackage

// File: rtl/icmp_responder_if.sv
// Transmit-side handshake between the ICMP responder (master) and the
// Ethernet transmit arbiter (slave).
interface icmp_responder_if;
    logic        tx_enable;
    logic        tx_request;
    logic        tx_active;
    logic [7:0]  tx_data;
    logic [15:0] length;
    logic [47:0] destination_mac;
    logic [31:0] destination_ip;

    modport master (
        input  tx_enable,
        output tx_request, tx_active, tx_data, length, destination_mac, destination_ip
    );

    modport slave (
        output tx_enable,
        input  tx_request, tx_active, tx_data, length, destination_mac, destination_ip
    );
endinterface

// File: rtl/icmp_responder_payload_ram.sv
// Echo payload buffer: single-clock simple dual-port RAM with registered read.
module icmp_responder_payload_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/icmp_responder.sv
// ICMP echo responder: buffers echo requests, optionally verifies their
// checksum, serves the echo reply to the tx arbiter and decodes type-3 packets.
module icmp_responder
    import icmp_responder_pkg::*;
#(
    parameter int MAX_PAYLOAD    = 512,
    parameter int VERIFY_RX_CSUM = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_enable,
    input  logic [7:0]       rx_data,
    input  logic [47:0]      remote_mac,
    input  logic [31:0]      remote_ip,
    icmp_responder_if.master tx,
    output logic             dst_unreachable,
    output logic [7:0]       unreach_code,
    output logic             rx_csum_error,
    output logic [CNT_W-1:0] drop_count
);
    localparam int AW = $clog2(MAX_PAYLOAD);
    localparam int PW = AW + 1;

    icmp_state_t      state_reg, state_next;
    logic             unreach_path_reg, unreach_path_next;
    logic [1:0]       hdr_idx_reg, hdr_idx_next;
    logic [31:0]      acc_reg, acc_next;
    logic [31:0]      pay_reg, pay_next;
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [15:0]      tx_idx_reg, tx_idx_next;
    logic [7:0]       tx_data_reg, tx_data_next;
    logic             tx_active_reg, tx_active_next;
    logic [15:0]      length_reg, length_next;
    logic [15:0]      reply_csum_reg, reply_csum_next;
    logic [47:0]      dmac_reg, dmac_next;
    logic [31:0]      dip_reg, dip_next;
    logic [7:0]       unreach_code_reg, unreach_code_next;
    logic             dst_unreach_reg, dst_unreach_next;
    logic             csum_err_reg, csum_err_next;
    logic [CNT_W-1:0] drop_count_reg, drop_count_next;
    logic             rx_enable_d_reg;

    logic             rx_rise;
    logic             drop_inc;
    logic             ram_we;
    logic [7:0]       ram_rdata;
    logic [31:0]      byte_word;
    logic [15:0]      acc_fold;
    logic [15:0]      pay_fold;

    assign rx_rise   = rx_enable & ~rx_enable_d_reg;
    // Even payload offsets are the high byte of a 16-bit word.
    assign byte_word = wr_ptr_reg[0] ? {24'h0, rx_data} : {16'h0, rx_data, 8'h00};
    assign acc_fold  = csum_fold(acc_reg);
    assign pay_fold  = csum_fold(pay_reg);

    icmp_responder_payload_ram #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr_reg),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next        = state_reg;
        unreach_path_next = unreach_path_reg;
        hdr_idx_next      = hdr_idx_reg;
        acc_next          = acc_reg;
        pay_next          = pay_reg;
        wr_ptr_next       = wr_ptr_reg;
        rd_ptr_next       = rd_ptr_reg;
        tx_idx_next       = tx_idx_reg;
        tx_data_next      = tx_data_reg;
        tx_active_next    = tx_active_reg;
        length_next       = length_reg;
        reply_csum_next   = reply_csum_reg;
        dmac_next         = dmac_reg;
        dip_next          = dip_reg;
        unreach_code_next = unreach_code_reg;
        dst_unreach_next  = 1'b0;
        csum_err_next     = 1'b0;
        drop_inc          = 1'b0;
        ram_we            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rx_rise) begin
                    dmac_next         = remote_mac;
                    dip_next          = remote_ip;
                    acc_next          = {16'h0, rx_data, 8'h00};
                    pay_next          = 32'h0;
                    wr_ptr_next       = '0;
                    rd_ptr_next       = '0;
                    hdr_idx_next      = 2'd0;
                    unreach_path_next = (rx_data == ICMP_TYPE_UNREACH);
                    if (rx_data == ICMP_TYPE_ECHO_REQ || rx_data == ICMP_TYPE_UNREACH) begin
                        state_next = HEADER;
                    end else begin
                        state_next = DISCARD;
                    end
                end
            end
            HEADER: begin
                if (!rx_enable) begin
                    drop_inc   = 1'b1;
                    state_next = IDLE;
                end else begin
                    case (hdr_idx_reg)
                        2'd0: begin
                            acc_next = acc_reg + {24'h0, rx_data};
                            if (unreach_path_reg) begin
                                unreach_code_next = rx_data;
                                dst_unreach_next  = 1'b1;
                                state_next        = DISCARD;
                            end else if (rx_data != 8'h00) begin
                                drop_inc   = 1'b1;
                                state_next = DISCARD;
                            end else begin
                                hdr_idx_next = 2'd1;
                            end
                        end
                        2'd1: begin
                            acc_next     = acc_reg + {16'h0, rx_data, 8'h00};
                            hdr_idx_next = 2'd2;
                        end
                        default: begin
                            acc_next   = acc_reg + {24'h0, rx_data};
                            state_next = PAYLOAD;
                        end
                    endcase
                end
            end
            PAYLOAD: begin
                if (!rx_enable) begin
                    state_next = CHECK;
                end else if (wr_ptr_reg == PW'(MAX_PAYLOAD)) begin
                    drop_inc   = 1'b1;
                    state_next = DISCARD;
                end else begin
                    ram_we      = 1'b1;
                    wr_ptr_next = wr_ptr_reg + PW'(1);
                    acc_next    = acc_reg + byte_word;
                    pay_next    = pay_reg + byte_word;
                end
            end
            CHECK: begin
                if (VERIFY_RX_CSUM != 0 && acc_fold != 16'hFFFF) begin
                    csum_err_next = 1'b1;
                    drop_inc      = 1'b1;
                    state_next    = IDLE;
                end else begin
                    length_next     = 16'(ICMP_HDR_LEN) + 16'(wr_ptr_reg);
                    reply_csum_next = ~pay_fold;
                    rd_ptr_next     = '0;
                    state_next      = TXREQ;
                end
            end
            TXREQ: begin
                if (tx.tx_enable) begin
                    tx_active_next = 1'b1;
                    tx_data_next   = ICMP_TYPE_ECHO_REP;
                    tx_idx_next    = 16'd1;
                    state_next     = TX;
                end
            end
            TX: begin
                if (tx_idx_reg == length_reg) begin
                    tx_active_next = 1'b0;
                    tx_data_next   = 8'h00;
                    tx_idx_next    = 16'd0;
                    wr_ptr_next    = '0;
                    rd_ptr_next    = '0;
                    state_next     = IDLE;
                end else begin
                    case (tx_idx_reg)
                        16'd1:   tx_data_next = 8'h00;
                        16'd2:   tx_data_next = reply_csum_reg[15:8];
                        16'd3:   tx_data_next = reply_csum_reg[7:0];
                        default: tx_data_next = ram_rdata;
                    endcase
                    tx_idx_next = tx_idx_reg + 16'd1;
                    // Read address runs one byte ahead to hide the RAM latency.
                    if (tx_idx_reg >= 16'd3) begin
                        rd_ptr_next = rd_ptr_reg + AW'(1);
                    end
                end
            end
            DISCARD: begin
                if (!rx_enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if ((state_reg == CHECK || state_reg == TXREQ || state_reg == TX) && rx_rise) begin
            drop_inc = 1'b1;
        end

        drop_count_next = drop_count_reg;
        if (drop_inc && drop_count_reg != {CNT_W{1'b1}}) begin
            drop_count_next = drop_count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            unreach_path_reg <= 1'b0;
            hdr_idx_reg      <= 2'd0;
            acc_reg          <= 32'h0;
            pay_reg          <= 32'h0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            tx_idx_reg       <= 16'd0;
            tx_data_reg      <= 8'h00;
            tx_active_reg    <= 1'b0;
            length_reg       <= 16'd0;
            reply_csum_reg   <= 16'd0;
            dmac_reg         <= 48'h0;
            dip_reg          <= 32'h0;
            unreach_code_reg <= 8'h00;
            dst_unreach_reg  <= 1'b0;
            csum_err_reg     <= 1'b0;
            drop_count_reg   <= '0;
            rx_enable_d_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            unreach_path_reg <= unreach_path_next;
            hdr_idx_reg      <= hdr_idx_next;
            acc_reg          <= acc_next;
            pay_reg          <= pay_next;
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            tx_idx_reg       <= tx_idx_next;
            tx_data_reg      <= tx_data_next;
            tx_active_reg    <= tx_active_next;
            length_reg       <= length_next;
            reply_csum_reg   <= reply_csum_next;
            dmac_reg         <= dmac_next;
            dip_reg          <= dip_next;
            unreach_code_reg <= unreach_code_next;
            dst_unreach_reg  <= dst_unreach_next;
            csum_err_reg     <= csum_err_next;
            drop_count_reg   <= drop_count_next;
            rx_enable_d_reg  <= rx_enable;
        end
    end

    assign tx.tx_request      = (state_reg == TXREQ);
    assign tx.tx_active       = tx_active_reg;
    assign tx.tx_data         = tx_data_reg;
    assign tx.length          = length_reg;
    assign tx.destination_mac = dmac_reg;
    assign tx.destination_ip  = dip_reg;
    assign dst_unreachable    = dst_unreach_reg;
    assign unreach_code       = unreach_code_reg;
    assign rx_csum_error      = csum_err_reg;
    assign drop_count         = drop_count_reg;
endmodule
